instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter OPCODEWIDTH, default 4, opcode field width.
REQ-002 Parameter ADDRWIDTH, default 8, instruction-memory address width.
REQ-003 Parameter DEPTH, default 4, encode-FIFO entries (power of two).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins a load session at baseAddr.
REQ-007 baseAddr  input  ADDRWIDTH  first memory address written in the session.
REQ-008 inValid / inReady  input / output  1 / 1  request handshake; transfer when both high.
REQ-009 inLast  input  1  marks the final request of the session.
REQ-010 obtainPCAsR1, writeEnable, writeDataEnable, resultSelector, data2Selector, outFlag  input  1 each  control bundle to encode.
REQ-011 aluControl  input  3  ALU control to encode.
REQ-012 branchSel  input  3  branch variant 0..4; used only when obtainPCAsR1=1.
REQ-013 rd, rs1  input  4 each  register fields; imm  input  12  immediate/rs2 field.
REQ-014 imemWe  output  1  memory write strobe; imemAddr  output  ADDRWIDTH; imemWData  output  24  = {opcode, rd, rs1, imm}.
REQ-015 busy, done, err  output  1 each  session status.

Function
REQ-016 Encoding SHALL invert the decoder table (x = don't care on data2Selector):
 - 0000 all zero, alu 000; 0001 writeDataEnable, alu 110; 0010 writeEnable, data2Selector=1, alu 111; 0011 writeEnable, alu 110;
 - 0100 outFlag, alu 110; 0101 writeEnable, data2Selector=0, alu 000; 0110 writeEnable, alu 001; 0111 writeEnable, resultSelector, alu 110;
 - 1000 writeEnable, alu 010; 1001 writeEnable, alu 101; 1010 alu 001, no write;
 - 1011+branchSel: obtainPCAsR1, data2Selector=1, alu 000, branchSel<=4.
REQ-017 Any other bundle, or branchSel>4 with obtainPCAsR1=1, SHALL be illegal.
REQ-018 States IDLE, LOAD, DRAIN, DONE; reset enters IDLE.
REQ-019 IDLE: start -> LOAD, write pointer := baseAddr, err := 0, done := 0; inReady=0 in IDLE and DONE.
REQ-020 LOAD: inReady = FIFO not full; each transfer encodes and pushes one 24-bit word.
REQ-021 A transfer with inLast=1 -> DRAIN; no further transfers accepted.
REQ-022 FIFO pops one word per cycle when non-empty in LOAD or DRAIN: imemWe=1, imemAddr=pointer, pointer increments modulo 2^ADDRWIDTH (wrap to 0 after all-ones).
REQ-023 Latency: request accepted in cycle N SHALL appear on imemWe in cycle N+1 at earliest (registered output).
REQ-024 Simultaneous push and pop on a full FIFO SHALL be allowed only via inReady=0; push and pop in the same cycle on a non-full FIFO keep occupancy constant.
REQ-025 DRAIN with FIFO empty -> DONE; done=1 for exactly one cycle, then IDLE.
REQ-026 start while not IDLE SHALL be ignored.
REQ-027 busy = 1 in LOAD and DRAIN, else 0.

Reset
REQ-028 rst SHALL immediately force IDLE, empty FIFO, pointer 0, imemWe/imemAddr/imemWData/busy/done/err = 0, inReady = 0, including mid-session; words not yet written are discarded.

Configuration
REQ-029 Macro INSTR_ENCODER_CHECK_EN defined: illegal requests are accepted but not pushed, err latches 1 until next start. Undefined: illegal requests encode as opcode 0000 with fields preserved and are written; err stays 0.

Verification
REQ-030 start baseAddr=0x10; one request writeEnable=1, alu 000, data2Selector=0, rd=3, rs1=1, imm=0x002, inLast=1 -> imemWe at 0x10, imemWData=0x531002, then done pulse.
REQ-031 Five branch requests branchSel 0..4 -> opcodes 1011..1111 at consecutive addresses.
REQ-032 baseAddr=0xFE, three requests -> addresses 0xFE, 0xFF, 0x00.
REQ-033 Hold memory path busy by streaming 6 requests back-to-back with DEPTH=4 -> inReady never lets occupancy exceed 4; all 6 words written in order.
REQ-034 Illegal bundle aluControl=011, writeEnable=1 -> with INSTR_ENCODER_CHECK_EN: no write, err=1; without: word with opcode 0000 written, err=0.
REQ-035 Assert rst after second of four requests -> outputs 0 immediately, IDLE, no further writes.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/memory bus of instr_encoder: control-bundle handshake in, encoded
// instruction-memory writes and session status out.
interface instr_encoder_if #(
  parameter int OPCODEWIDTH = 4,
  parameter int ADDRWIDTH   = 8
);
  logic                      start;
  logic [ADDRWIDTH-1:0]      baseAddr;
  logic                      inValid;
  logic                      inReady;
  logic                      inLast;
  logic                      obtainPCAsR1;
  logic                      writeEnable;
  logic                      writeDataEnable;
  logic                      resultSelector;
  logic                      data2Selector;
  logic                      outFlag;
  logic [2:0]                aluControl;
  logic [2:0]                branchSel;
  logic [3:0]                rd;
  logic [3:0]                rs1;
  logic [11:0]               imm;
  logic                      imemWe;
  logic [ADDRWIDTH-1:0]      imemAddr;
  logic [OPCODEWIDTH+19:0]   imemWData;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    output start, baseAddr, inValid, inLast,
    output obtainPCAsR1, writeEnable, writeDataEnable, resultSelector,
    output data2Selector, outFlag, aluControl, branchSel, rd, rs1, imm,
    input  inReady, imemWe, imemAddr, imemWData, busy, done, err
  );

  modport slave (
    input  start, baseAddr, inValid, inLast,
    input  obtainPCAsR1, writeEnable, writeDataEnable, resultSelector,
    input  data2Selector, outFlag, aluControl, branchSel, rd, rs1, imm,
    output inReady, imemWe, imemAddr, imemWData, busy, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes control bundles into 24-bit instruction words and streams them into
// instruction memory through a small FIFO. Optional macro: INSTR_ENCODER_CHECK_EN.
module instr_encoder #(
  parameter int OPCODEWIDTH = 4,
  parameter int ADDRWIDTH   = 8,
  parameter int DEPTH       = 4
) (
  input logic             clk,
  input logic             rst,
  instr_encoder_if.slave  bus
);
  localparam int WW = OPCODEWIDTH + 20;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Returns {legal, opcode}; an illegal bundle yields opcode 0000.
  function automatic logic [4:0] encode(input logic pc, input logic we,
                                        input logic wde, input logic rs,
                                        input logic d2, input logic of,
                                        input logic [2:0] alu,
                                        input logic [2:0] bsel);
    logic [4:0] r;
    r = 5'b0_0000;
    casez ({pc, we, wde, rs, d2, of, alu})
      9'b0_000?0_000: r = 5'b1_0000;
      9'b0_010?0_110: r = 5'b1_0001;
      9'b0_10010_111: r = 5'b1_0010;
      9'b0_100?0_110: r = 5'b1_0011;
      9'b0_000?1_110: r = 5'b1_0100;
      9'b0_10000_000: r = 5'b1_0101;
      9'b0_100?0_001: r = 5'b1_0110;
      9'b0_101?0_110: r = 5'b1_0111;
      9'b0_100?0_010: r = 5'b1_1000;
      9'b0_100?0_101: r = 5'b1_1001;
      9'b0_000?0_001: r = 5'b1_1010;
      9'b1_00010_000: begin
        if (bsel <= 3'd4) begin
          r = {1'b1, 4'd11 + {1'b0, bsel}};
        end else begin
          r = 5'b0_0000;
        end
      end
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  state_t               state_r, state_next_s;
  logic [WW-1:0]        fifo_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [PW:0]          count_r;
  logic [ADDRWIDTH-1:0] addr_r, imem_addr_r;
  logic [WW-1:0]        imem_wdata_r, word_s;
  logic                 imem_we_r, busy_r, done_r, err_r;
  logic [4:0]           enc_s;
  logic                 in_ready_s, xfer_s, push_s, pop_s, illegal_s;

  // Next-state decode, handshake and FIFO push/pop qualification
  always_comb begin
    state_next_s = state_r;
    enc_s = encode(bus.obtainPCAsR1, bus.writeEnable, bus.writeDataEnable,
                   bus.resultSelector, bus.data2Selector, bus.outFlag,
                   bus.aluControl, bus.branchSel);
    word_s     = {OPCODEWIDTH'(enc_s[3:0]), bus.rd, bus.rs1, bus.imm};
    in_ready_s = (state_r == LOAD) && (count_r != (PW+1)'(DEPTH));
    xfer_s     = in_ready_s && bus.inValid;
`ifdef INSTR_ENCODER_CHECK_EN
    push_s    = xfer_s && enc_s[4];
    illegal_s = xfer_s && !enc_s[4];
`else
    push_s    = xfer_s;
    illegal_s = 1'b0;
`endif
    pop_s = ((state_r == LOAD) || (state_r == DRAIN)) && (count_r != '0);
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = LOAD;
        else           state_next_s = IDLE;
      end
      LOAD: begin
        if (xfer_s && bus.inLast) state_next_s = DRAIN;
        else                      state_next_s = LOAD;
      end
      DRAIN: begin
        if (count_r == '0) state_next_s = DONE;
        else               state_next_s = DRAIN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care whenever the pointers say empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= word_s;
    end
  end

  // Session state, FIFO bookkeeping, memory write port and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      addr_r       <= '0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
      imem_we_r <= pop_s;
      if (pop_s) begin
        imem_addr_r  <= addr_r;
        imem_wdata_r <= fifo_r[rd_ptr_r];
      end
      if ((state_r == IDLE) && bus.start) begin
        addr_r <= bus.baseAddr;
        err_r  <= 1'b0;
      end else if (pop_s) begin
        addr_r <= addr_r + ADDRWIDTH'(1);
      end else if (illegal_s) begin
        err_r <= 1'b1;
      end
      // pop and illegal can coincide; err must not be lost in that case
      if (pop_s && illegal_s) err_r <= 1'b1;
      busy_r <= (state_next_s == LOAD) || (state_next_s == DRAIN);
      done_r <= (state_next_s == DONE);
    end
  end

  assign bus.inReady   = in_ready_s;
  assign bus.imemWe    = imem_we_r;
  assign bus.imemAddr  = imem_addr_r;
  assign bus.imemWData = imem_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed sessions plus a randomized
// session, scored against a table-driven reference model and address counter.
module tb_instr_encoder;
  localparam int DEPTH = 4;

  typedef struct packed {
    bit        pc, we, wde, rs, d2, of;
    bit [2:0]  alu, bsel;
    bit [3:0]  rd, rs1;
    bit [11:0] imm;
  } req_t;

  // Decoder table rows for opcodes 0..10: {we,wde,rs,of}, alu, d2 (2 = any)
  localparam bit [3:0] ROW_F [11] = '{4'b0000, 4'b0100, 4'b1000, 4'b1000, 4'b0001,
                                      4'b1000, 4'b1000, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
  localparam bit [2:0] ROW_A [11] = '{3'd0, 3'd6, 3'd7, 3'd6, 3'd6, 3'd0, 3'd1, 3'd6,
                                      3'd2, 3'd5, 3'd1};
  localparam int       ROW_D [11] = '{2, 2, 1, 2, 2, 0, 2, 2, 2, 2, 2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_encoder_if #(.OPCODEWIDTH(4), .ADDRWIDTH(8)) bus ();
  instr_encoder #(.OPCODEWIDTH(4), .ADDRWIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]  exp_addr_q [$];
  logic [23:0] exp_data_q [$];
  logic [7:0]  model_ptr = 8'h00;
  bit          model_err = 1'b0;
  int          accepted = 0;
  int          written = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_opcode(input req_t r);
    if (r.pc) begin
      if (r.we || r.wde || r.rs || r.of || !r.d2 || r.alu != 3'd0 || r.bsel > 3'd4) return -1;
      return 11 + int'(r.bsel);
    end
    for (int i = 0; i < 11; i++) begin
      if ({r.we, r.wde, r.rs, r.of} == ROW_F[i] && r.alu == ROW_A[i] &&
          (ROW_D[i] == 2 || ROW_D[i] == int'(r.d2))) return i;
    end
    return -1;
  endfunction

  function automatic req_t make_legal(input int k, input req_t base);
    req_t r;
    r = base;
    if (k < 11) begin
      r.pc = 1'b0;
      {r.we, r.wde, r.rs, r.of} = ROW_F[k];
      r.alu = ROW_A[k];
      if (ROW_D[k] != 2) r.d2 = (ROW_D[k] == 1);
    end else begin
      {r.pc, r.we, r.wde, r.rs, r.d2, r.of} = 6'b100010;
      r.alu  = 3'd0;
      r.bsel = 3'(k - 11);
    end
    return r;
  endfunction

  task automatic model_accept(input req_t r);
    int opc;
    opc = ref_opcode(r);
`ifdef INSTR_ENCODER_CHECK_EN
    if (opc < 0) begin
      model_err = 1'b1;
      return;
    end
`else
    if (opc < 0) opc = 0;
`endif
    exp_addr_q.push_back(model_ptr);
    exp_data_q.push_back({4'(opc), r.rd, r.rs1, r.imm});
    model_ptr = model_ptr + 8'd1;
    accepted++;
  endtask

  // Caller is at a falling edge; returns at the falling edge after the transfer
  task automatic send(input req_t r, input bit last);
    bit ok;
    {bus.obtainPCAsR1, bus.writeEnable, bus.writeDataEnable} = {r.pc, r.we, r.wde};
    {bus.resultSelector, bus.data2Selector, bus.outFlag} = {r.rs, r.d2, r.of};
    bus.aluControl = r.alu;
    bus.branchSel  = r.bsel;
    bus.rd  = r.rd;
    bus.rs1 = r.rs1;
    bus.imm = r.imm;
    bus.inLast  = last;
    bus.inValid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.inReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      model_accept(r);
      @(negedge clk);
    end else begin
      check("inready_timeout", 32'd0, 32'd1);
    end
    bus.inValid = 1'b0;
    bus.inLast  = 1'b0;
  endtask

  task automatic begin_session(input logic [7:0] base);
    bus.baseAddr = base;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    model_ptr = base;
    model_err = 1'b0;
    check("busy_after_start", bus.busy, 32'd1);
    check("err_cleared_by_start", bus.err, 32'd0);
  endtask

  task automatic finish_session(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 32'd1);
    check({tag, "_all_written"}, exp_addr_q.size(), 32'd0);
    check({tag, "_busy_at_done"}, bus.busy, 32'd0);
    check({tag, "_err"}, bus.err, model_err);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, bus.done, 32'd0);
    check({tag, "_inready_idle"}, bus.inReady, 32'd0);
    check({tag, "_err_held"}, bus.err, model_err);
  endtask

  // Scoreboard for memory writes and FIFO occupancy bound
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.imemWe === 1'b1) begin
        written++;
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          check("imem_addr", bus.imemAddr, exp_addr_q.pop_front());
          check("imem_wdata", bus.imemWData, exp_data_q.pop_front());
        end
      end
      if (bus.busy === 1'b1) check("occupancy_le_depth", (accepted - written) <= DEPTH, 32'd1);
    end
  end

  initial begin
    req_t r;
    rst = 1'b1;
    {bus.start, bus.inValid, bus.inLast, bus.obtainPCAsR1, bus.writeEnable} = '0;
    {bus.writeDataEnable, bus.resultSelector, bus.data2Selector, bus.outFlag} = '0;
    bus.baseAddr = 8'h00; bus.aluControl = 3'd0; bus.branchSel = 3'd0;
    bus.rd = 4'd0; bus.rs1 = 4'd0; bus.imm = 12'd0;
    repeat (2) @(negedge clk);
    check("rst_we", bus.imemWe, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_err", bus.err, 32'd0);
    check("rst_inready", bus.inReady, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_inready", bus.inReady, 32'd0);

    // Single store-type request: expect 0x531002 at 0x10
    begin_session(8'h10);
    r = '0; r.we = 1'b1; r.rd = 4'd3; r.rs1 = 4'd1; r.imm = 12'h002;
    check("model_single_word", {4'(ref_opcode(r)), r.rd, r.rs1, r.imm}, 32'h531002);
    send(r, 1'b1);
    finish_session("single");

    // Five branch variants
    begin_session(8'h20);
    for (int i = 0; i < 5; i++) send(make_legal(11 + i, req_t'($urandom)), i == 4);
    finish_session("branch");

    // Address wrap
    begin_session(8'hFE);
    for (int i = 0; i < 3; i++) send(make_legal(int'($urandom_range(0, 10)), req_t'($urandom)), i == 2);
    finish_session("wrap");

    // Six back-to-back requests
    begin_session(8'h30);
    for (int i = 0; i < 6; i++) send(make_legal(int'($urandom_range(0, 15)), req_t'($urandom)), i == 5);
    finish_session("stream");

    // Illegal bundle: aluControl=011 with writeEnable
    begin_session(8'h40);
    r = '0; r.we = 1'b1; r.alu = 3'b011; r.rd = 4'd7; r.imm = 12'hABC;
    check("model_illegal", ref_opcode(r), 32'hFFFF_FFFF);
    send(r, 1'b1);
    finish_session("illegal");
    begin_session(8'h48);
    send(make_legal(3, req_t'($urandom)), 1'b1);
    finish_session("after_illegal");

    // Randomized session with gaps, illegal mixes and an ignored start
    begin_session(8'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) r = req_t'($urandom);
      else r = make_legal(int'($urandom_range(0, 15)), req_t'($urandom));
      if (i == 10) begin
        bus.baseAddr = 8'hAA;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(r, i == 19);
    end
    finish_session("random");

    // Reset in the middle of a four-request session
    begin_session(8'h60);
    for (int i = 0; i < 2; i++) send(make_legal(int'($urandom_range(0, 10)), req_t'($urandom)), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_we", bus.imemWe, 32'd0);
    check("midrst_addr", bus.imemAddr, 32'd0);
    check("midrst_wdata", bus.imemWData, 32'd0);
    check("midrst_busy", bus.busy, 32'd0);
    check("midrst_done", bus.done, 32'd0);
    check("midrst_err", bus.err, 32'd0);
    check("midrst_inready", bus.inReady, 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    accepted = 0;
    written = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("postrst_idle_busy", bus.busy, 32'd0);
    check("postrst_idle_inready", bus.inReady, 32'd0);
    begin_session(8'h70);
    send(make_legal(0, req_t'($urandom)), 1'b1);
    finish_session("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
